// File: rtl/fpalu_share_arb.sv
// Shares one pipelined FPALU among NREQ requesters: round-robin issue with optional lock
// ownership, registered operand port, and a tag pipe that returns each result to its issuer.
module fpalu_share_arb #(
    parameter int NREQ    = 4,
    parameter int LAT     = 5,
    parameter int W       = 29,
    parameter int MAXLOCK = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_lock,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                alu_issue,
    output logic [1:0]          alu_opcode,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    input  logic [W-1:0]        alu_y,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [W-1:0]        rsp_y,
    output logic                busy,
    output logic [2:0]          grant_id
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAXLOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXLOCK);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NREQ - 1);

    function automatic logic [NREQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        id_onehot = {{(NREQ-1){1'b0}}, 1'b1} << id;
    endfunction

    logic [ID_W-1:0]  grant_id_r;
    logic [ID_W-1:0]  owner_id_r;
    logic             owner_valid_r;
    logic [CNT_W-1:0] lock_cnt_r;
    logic             alu_issue_r;
    logic [1:0]       alu_opcode_r;
    logic [W-1:0]     alu_a_r;
    logic [W-1:0]     alu_b_r;
    logic [LAT-1:0]   tag_valid_r;
    logic [ID_W-1:0]  tag_id_r [LAT];
    logic             busy_r;

    logic             lock_active_s;
    logic             others_valid_s;
    logic             rr_found_s;
    logic             xfer_s;
    logic [ID_W-1:0]  rr_cand_s;
    logic [ID_W-1:0]  rr_win_s;
    logic [ID_W-1:0]  win_s;
    logic             owner_valid_n_s;
    logic [ID_W-1:0]  owner_id_n_s;
    logic [CNT_W-1:0] lock_cnt_n_s;
    logic [LAT-1:0]   tag_valid_n_s;

    // Lock qualification of the current owner and contention from everybody else
    always_comb begin
        lock_active_s  = owner_valid_r & req_lock[owner_id_r] & (lock_cnt_r < CNT_MAX);
        others_valid_s = |(req_valid & ~id_onehot(owner_id_r));
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        rr_found_s = 1'b0;
        rr_win_s   = {ID_W{1'b0}};
        rr_cand_s  = {ID_W{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand_s = ID_W'((int'(grant_id_r) + k) % NREQ);
            if (!rr_found_s && req_valid[rr_cand_s]) begin
                rr_found_s = 1'b1;
                rr_win_s   = rr_cand_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Winner selection: an active lock starves everyone else, bubbles included
    always_comb begin
        xfer_s = 1'b0;
        win_s  = rr_win_s;
        if (!rst_n || hold) begin
            xfer_s = 1'b0;
        end else if (lock_active_s) begin
            xfer_s = req_valid[owner_id_r];
            win_s  = owner_id_r;
        end else begin
            xfer_s = rr_found_s;
        end
        req_ready = xfer_s ? id_onehot(win_s) : {NREQ{1'b0}};
    end

    // Next owner and lock counter; an expired lock gets one round-robin cycle then restarts
    always_comb begin
        owner_valid_n_s = 1'b0;
        owner_id_n_s    = owner_id_r;
        lock_cnt_n_s    = lock_cnt_r;
        if (xfer_s) begin
            owner_valid_n_s = req_lock[win_s];
            owner_id_n_s    = win_s;
        end else if (lock_active_s || (hold && owner_valid_r && req_lock[owner_id_r])) begin
            owner_valid_n_s = owner_valid_r;
        end else begin
            owner_valid_n_s = 1'b0;
        end
        if (!owner_valid_n_s || !owner_valid_r || (owner_id_n_s != owner_id_r)) begin
            lock_cnt_n_s = {CNT_W{1'b0}};
        end else if (!hold && !lock_active_s) begin
            lock_cnt_n_s = {CNT_W{1'b0}};
        end else if (others_valid_s && (lock_cnt_r < CNT_MAX)) begin
            lock_cnt_n_s = lock_cnt_r + CNT_W'(1);
        end else begin
            lock_cnt_n_s = lock_cnt_r;
        end
    end

    // Tag pipe advance: stage 0 takes whatever is on the ALU port this cycle
    always_comb begin
        tag_valid_n_s = (tag_valid_r << 1) | LAT'(alu_issue_r);
    end

    // Arbitration state and registered FPALU operand port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_id_r    <= ID_LAST;
            owner_valid_r <= 1'b0;
            owner_id_r    <= {ID_W{1'b0}};
            lock_cnt_r    <= {CNT_W{1'b0}};
            alu_issue_r   <= 1'b0;
            alu_opcode_r  <= 2'b00;
            alu_a_r       <= {W{1'b0}};
            alu_b_r       <= {W{1'b0}};
        end else begin
            owner_valid_r <= owner_valid_n_s;
            owner_id_r    <= owner_id_n_s;
            lock_cnt_r    <= lock_cnt_n_s;
            alu_issue_r   <= xfer_s;
            if (xfer_s) begin
                grant_id_r   <= win_s;
                alu_opcode_r <= req_op[2*int'(win_s) +: 2];
                alu_a_r      <= req_a[W*int'(win_s) +: W];
                alu_b_r      <= req_b[W*int'(win_s) +: W];
            end else begin
                grant_id_r   <= grant_id_r;
                alu_opcode_r <= alu_opcode_r;
                alu_a_r      <= alu_a_r;
                alu_b_r      <= alu_b_r;
            end
        end
    end

    // Tag pipe and busy flag; reset drops every in-flight tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                tag_id_r[i] <= {ID_W{1'b0}};
            end
            busy_r <= 1'b0;
        end else begin
            tag_valid_r <= tag_valid_n_s;
            tag_id_r[0] <= grant_id_r;
            for (int i = 1; i < LAT; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
            busy_r <= xfer_s | (|tag_valid_n_s);
        end
    end

    assign alu_issue  = alu_issue_r;
    assign alu_opcode = alu_opcode_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign busy       = busy_r;
    assign grant_id   = 3'(grant_id_r);
    assign rsp_y      = alu_y;
    assign rsp_valid  = (rst_n && tag_valid_r[LAT-1]) ? id_onehot(tag_id_r[LAT-1]) : {NREQ{1'b0}};

endmodule

// File: tb/tb_fpalu_share_arb.sv
// Directed bench for fpalu_share_arb with a behavioural FPALU stand-in and expected-response pipe.
module tb_fpalu_share_arb;
    localparam int NREQ = 4;
    localparam int LAT  = 5;
    localparam int W    = 29;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_lock;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              alu_issue;
    logic [1:0]        alu_opcode;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_y;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_y;
    logic              busy;
    logic [2:0]        grant_id;

    int checks = 0;
    int errors = 0;

    logic            exp_v   [LAT+1];
    logic [NREQ-1:0] exp_hot [LAT+1];
    logic [W-1:0]    exp_y   [LAT+1];
    logic [W-1:0]    alu_pipe [LAT];

    fpalu_share_arb #(.NREQ(NREQ), .LAT(LAT), .W(W), .MAXLOCK(64)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_lock(req_lock), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .alu_issue(alu_issue), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    alu_model = a + b;
            2'd1:    alu_model = a - b;
            2'd2:    alu_model = a ^ b;
            default: alu_model = a & b;
        endcase
    endfunction

    // FPALU stand-in: fixed LAT-cycle pipeline from operand capture to alu_y
    always @(posedge clk) begin
        alu_pipe[0] <= alu_model(alu_opcode, alu_a, alu_b);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_y = alu_pipe[LAT-1];

    function automatic logic [NREQ-1:0] hot(input int id);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        hot = one << id;
    endfunction

    // Push this cycle's expected grant into the response model and advance one clock
    task automatic step(input logic v, input int id);
        for (int i = LAT; i > 0; i--) begin
            exp_v[i] = exp_v[i-1]; exp_hot[i] = exp_hot[i-1]; exp_y[i] = exp_y[i-1];
        end
        exp_v[0]   = v;
        exp_hot[0] = hot(id);
        exp_y[0]   = alu_model(req_op[2*id +: 2], req_a[W*id +: W], req_b[W*id +: W]);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; hold = 1'b0; req_valid = 4'hF; req_lock = 4'h0;
        @(posedge clk); #1; @(posedge clk); #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        checks++; if (alu_issue !== 1'b0) begin errors++; $display("FAIL reset_issue got=%b want=0", alu_issue); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp got=%b want=0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL reset_grant_id got=%0d want=3", grant_id); end
        checks++; if ({alu_opcode, alu_a, alu_b} !== {2'b00, {W{1'b0}}, {W{1'b0}}}) begin
            errors++; $display("FAIL reset_alu_port got=%h/%h/%h want=0", alu_opcode, alu_a, alu_b);
        end
        rst_n = 1'b1; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
        req_valid = 4'h0; #1;
        step(1'b0, 0);
    endtask

    task automatic test_round_robin;
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (req_ready !== hot(k % 4)) begin errors++; $display("FAIL rr_order k=%0d got=%b want=%b", k, req_ready, hot(k % 4)); end
            checks++; if (alu_issue !== (k > 0)) begin errors++; $display("FAIL rr_issue k=%0d got=%b want=%b", k, alu_issue, (k > 0)); end
            if (k > 0) begin
                checks++; if (alu_a !== req_a[W*((k-1)%4) +: W]) begin
                    errors++; $display("FAIL rr_alu_a k=%0d got=%h want=%h", k, alu_a, req_a[W*((k-1)%4) +: W]);
                end
            end
            checks++;
            if ((rsp_valid !== (exp_v[LAT] ? exp_hot[LAT] : 4'b0000)) || (exp_v[LAT] && (rsp_y !== exp_y[LAT]))) begin
                errors++; $display("FAIL rr_rsp k=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_y, exp_v[LAT] ? exp_hot[LAT] : 4'b0000, exp_y[LAT]);
            end
            step(1'b1, k % 4);
        end
        req_valid = 4'h0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ((rsp_valid !== (exp_v[LAT] ? exp_hot[LAT] : 4'b0000)) || (exp_v[LAT] && (rsp_y !== exp_y[LAT]))) begin
                errors++; $display("FAIL rr_drain_rsp k=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_y, exp_v[LAT] ? exp_hot[LAT] : 4'b0000, exp_y[LAT]);
            end
            checks++; if (busy !== (k < 6)) begin errors++; $display("FAIL rr_busy k=%0d got=%b want=%b", k, busy, (k < 6)); end
            step(1'b0, 0);
        end
    endtask

    task automatic test_hold;
        req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_pre0 got=%b want=0001", req_ready); end
        step(1'b1, 0);
        req_valid = 4'b0010; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_pre1 got=%b want=0010", req_ready); end
        step(1'b1, 1);
        hold = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready j=%0d got=%b want=0000", j, req_ready); end
            checks++; if (alu_issue !== (j == 0)) begin errors++; $display("FAIL hold_issue j=%0d got=%b want=%b", j, alu_issue, (j == 0)); end
            checks++;
            if ((rsp_valid !== (exp_v[LAT] ? exp_hot[LAT] : 4'b0000)) || (exp_v[LAT] && (rsp_y !== exp_y[LAT]))) begin
                errors++; $display("FAIL hold_rsp j=%0d got=%b/%h want=%b/%h", j, rsp_valid, rsp_y, exp_v[LAT] ? exp_hot[LAT] : 4'b0000, exp_y[LAT]);
            end
            step(1'b0, 0);
        end
        hold = 1'b0; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_release got=%b want=0010", req_ready); end
        step(1'b1, 1);
        req_valid = 4'h0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ((rsp_valid !== (exp_v[LAT] ? exp_hot[LAT] : 4'b0000)) || (exp_v[LAT] && (rsp_y !== exp_y[LAT]))) begin
                errors++; $display("FAIL hold_drain_rsp k=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_y, exp_v[LAT] ? exp_hot[LAT] : 4'b0000, exp_y[LAT]);
            end
            step(1'b0, 0);
        end
    endtask

    task automatic test_back_to_back;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready k=%0d got=%b want=0010", k, req_ready); end
            if (k > 0) begin
                checks++; if ((alu_issue !== 1'b1) || (alu_b !== req_b[W*1 +: W])) begin
                    errors++; $display("FAIL b2b_issue k=%0d got=%b/%h want=1/%h", k, alu_issue, alu_b, req_b[W*1 +: W]);
                end
            end
            step(1'b1, 1);
        end
        req_valid = 4'h0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ((rsp_valid !== (exp_v[LAT] ? exp_hot[LAT] : 4'b0000)) || (exp_v[LAT] && (rsp_y !== exp_y[LAT]))) begin
                errors++; $display("FAIL b2b_rsp k=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_y, exp_v[LAT] ? exp_hot[LAT] : 4'b0000, exp_y[LAT]);
            end
            step(1'b0, 0);
        end
    endtask

    task automatic test_lock;
        logic [NREQ-1:0] want;
        req_valid = 4'b0100; req_lock = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_take got=%b want=0100", req_ready); end
        step(1'b1, 2);
        for (int k = 0; k < 64; k++) begin
            req_valid = (k % 6 == 0) ? 4'b0111 : 4'b0011;
            want      = (k % 6 == 0) ? 4'b0100 : 4'b0000;
            #1;
            checks++; if (req_ready !== want) begin errors++; $display("FAIL lock_hold k=%0d got=%b want=%b", k, req_ready, want); end
            step(k % 6 == 0, 2);
        end
        req_valid = 4'b0011; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_expire got=%b want=0001", req_ready); end
        step(1'b1, 0);
        req_valid = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_reown got=%b want=0100", req_ready); end
        step(1'b1, 2);
        req_valid = 4'b0111; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_owner_only got=%b want=0100", req_ready); end
        step(1'b1, 2);
        req_valid = 4'b0011; #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lock_bubble got=%b want=0000", req_ready); end
        step(1'b0, 0);
    endtask

    task automatic test_lock_release;
        req_valid = 4'b1111; req_lock = 4'b0000; #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_release got=%b want=1000", req_ready); end
        step(1'b1, 3);
        req_valid = 4'h0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ((rsp_valid !== (exp_v[LAT] ? exp_hot[LAT] : 4'b0000)) || (exp_v[LAT] && (rsp_y !== exp_y[LAT]))) begin
                errors++; $display("FAIL lock_drain_rsp k=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_y, exp_v[LAT] ? exp_hot[LAT] : 4'b0000, exp_y[LAT]);
            end
            step(1'b0, 0);
        end
    endtask

    task automatic test_midflight_reset;
        for (int k = 0; k < 3; k++) begin
            req_valid = hot(k); #1;
            checks++; if (req_ready !== hot(k)) begin errors++; $display("FAIL mid_issue k=%0d got=%b want=%b", k, req_ready, hot(k)); end
            step(1'b0, 0);
        end
        req_valid = 4'h0; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
        step(1'b0, 0);
        step(1'b0, 0);
        rst_n = 1'b0; req_valid = 4'hF; #1;
        checks++; if ((req_ready !== 4'b0000) || (rsp_valid !== 4'b0000)) begin
            errors++; $display("FAIL mid_in_reset got=%b/%b want=0000/0000", req_ready, rsp_valid);
        end
        step(1'b0, 0);
        rst_n = 1'b1; req_valid = 4'h0;
        for (int j = 0; j < 10; j++) begin
            #1;
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_rsp j=%0d got=%b want=0000", j, rsp_valid); end
            if (j == 0) begin
                checks++; if ((busy !== 1'b0) || (grant_id !== 3'd3)) begin
                    errors++; $display("FAIL mid_after_reset busy/grant_id got=%b/%0d want=0/3", busy, grant_id);
                end
            end
            step(1'b0, 0);
        end
        req_valid = 4'hF; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b want=0001", req_ready); end
        req_valid = 4'h0; #1;
        step(1'b0, 0);
    endtask

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            exp_v[i] = 1'b0; exp_hot[i] = 4'b0000; exp_y[i] = {W{1'b0}};
        end
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2] = 2'(i);
            req_a[W*i +: W]  = W'(32'h0123_4567 + 32'(i) * 32'h0010_1011);
            req_b[W*i +: W]  = W'(32'h0765_4321 - 32'(i) * 32'h0003_0303);
        end
        test_reset();
        test_round_robin();
        test_hold();
        test_back_to_back();
        test_lock();
        test_lock_release();
        test_midflight_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
